// File: rtl/bictr_pkg.sv
// Shared definitions for the up/down counter family and its checker.
// Holds the checker FSM state type and the counter's next-value rule so
// any block modelling the counter applies exactly the same priority order.
package bictr_pkg;

    // Widest counter the shared next-count helper can model.
    localparam int MAX_W = 64;

    // Checker tracking states.
    typedef enum logic [1:0] {
        ST_UNSYNC = 2'd0,
        ST_TRACK  = 2'd1,
        ST_HALT   = 2'd2
    } state_t;

    // Next counter value from the current value and the sampled controls.
    // Load (active-low) beats count enable; stepping wraps naturally once
    // the caller truncates the result back to its own width.
    // The counter's own active-low reset is handled by the caller because
    // it overrides everything, including load.
    function automatic logic [MAX_W-1:0] next_count(
        input logic [MAX_W-1:0] cur,
        input logic             load_n,
        input logic [MAX_W-1:0] data,
        input logic             cen,
        input logic             up_dn
    );
        logic [MAX_W-1:0] nxt;
        nxt = cur;
        if (!load_n) begin
            nxt = data;
        end else if (cen) begin
            nxt = up_dn ? (cur + 1'b1) : (cur - 1'b1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bictr_checker_if.sv
// Observation bundle between an up/down counter and its companion checker.
// The master side drives the counter's controls and outputs (the counter
// or a bench standing in for it); the slave side is the checker, which
// only observes those and drives its own status outputs.
interface bictr_checker_if #(
    parameter int WIDTH  = 8,
    parameter int STAT_W = 16
);
    // Observed counter controls and outputs.
    logic              dut_reset_n;
    logic              load;
    logic              cen;
    logic              up_dn;
    logic [WIDTH-1:0]  data;
    logic [WIDTH-1:0]  count_to;
    logic [WIDTH-1:0]  count;
    logic              tercnt;

    // Checker status outputs.
    logic              synced;
    logic              mismatch;
    logic              err_sticky;
    logic [STAT_W-1:0] err_cnt;
    logic [STAT_W-1:0] term_cnt;
    logic [WIDTH-1:0]  exp_count;

    modport master (
        output dut_reset_n, load, cen, up_dn, data, count_to, count, tercnt,
        input  synced, mismatch, err_sticky, err_cnt, term_cnt, exp_count
    );

    modport slave (
        input  dut_reset_n, load, cen, up_dn, data, count_to, count, tercnt,
        output synced, mismatch, err_sticky, err_cnt, term_cnt, exp_count
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating event counter used for the checker statistics.
// Counts one per cycle while inc is high and sticks at all-ones so a long
// run of events never wraps back to a small, misleading number.
module sat_counter #(
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inc,
    input  logic              clr,
    output logic [STAT_W-1:0] value
);

    logic [STAT_W-1:0] r_value;

    // Clear has priority; otherwise step until the all-ones ceiling.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_value <= '0;
        end else if (clr) begin
            r_value <= '0;
        end else if (inc && (r_value != {STAT_W{1'b1}})) begin
            r_value <= r_value + 1'b1;
        end
    end

    assign value = r_value;

endmodule

// File: rtl/bictr_checker.sv
// Companion checker for the up/down binary counter with count-to flag.
// Runs a cycle-accurate shadow of the counter, compares the observed count
// and terminal-count flag against it every cycle once seeded, and keeps
// saturating error and terminal-count statistics.
//
// The shadow predicts the value the counter will show after edge N from the
// controls sampled at edge N; that prediction is checked at edge N+1.
// Before the first observed counter reset or load the counter's value is
// unknown, so the checker waits in UNSYNC and makes no comparisons.
// After an error the shadow is reseeded from the observed count, so one
// corrupted value is reported once rather than on every following cycle.
// The interface's WIDTH/STAT_W parameters must equal this module's.
module bictr_checker
    import bictr_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int STAT_W      = 16,
    parameter int STOP_ON_ERR = 0
) (
    input logic             clk,
    input logic             reset,
    bictr_checker_if.slave  bus
);

    state_t             r_state;
    logic [WIDTH-1:0]   r_exp;
    logic               r_mismatch;
    logic               r_sticky;
    logic               r_prev_ter;

    logic               w_track;
    logic               w_seed;
    logic               w_cnt_err;
    logic               w_ter_err;
    logic               w_err;
    logic               w_ter_rise;
    logic [WIDTH-1:0]   w_base;
    logic [WIDTH-1:0]   w_next;
    logic [STAT_W-1:0]  w_err_cnt;
    logic [STAT_W-1:0]  w_term_cnt;

    assign w_track = (r_state == ST_TRACK);

    // A counter reset or load makes the counter's next value known.
    assign w_seed = !bus.dut_reset_n || !bus.load;

    // The count must match the shadow, and the flag must match the
    // observed count against the observed terminal value.
    assign w_cnt_err = (bus.count != r_exp);
    assign w_ter_err = (bus.tercnt != (bus.count == bus.count_to));
    assign w_err     = w_track && (w_cnt_err || w_ter_err);

    // Terminal-count rising edge, only counted while actively tracking.
    assign w_ter_rise = w_track && !r_prev_ter && bus.tercnt;

    // Step from the observed count after an error, else from the shadow.
    assign w_base = w_err ? bus.count : r_exp;

    // Shadow next value: counter reset forces zero, otherwise the shared rule.
    always_comb begin
        w_next = WIDTH'(next_count(MAX_W'(w_base), bus.load, MAX_W'(bus.data),
                                   bus.cen, bus.up_dn));
        if (!bus.dut_reset_n) begin
            w_next = '0;
        end
    end

    // Tracking FSM and shadow count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_UNSYNC;
            r_exp   <= '0;
        end else begin
            case (r_state)
                ST_UNSYNC: begin
                    if (w_seed) begin
                        r_exp   <= w_next;
                        r_state <= ST_TRACK;
                    end
                end
                ST_TRACK: begin
                    r_exp <= w_next;
                    if ((STOP_ON_ERR != 0) && w_err) begin
                        r_state <= ST_HALT;
                    end
                end
                ST_HALT: begin
                    r_state <= ST_HALT;
                end
                default: begin
                    r_state <= ST_UNSYNC;
                end
            endcase
        end
    end

    // Error pulse and sticky flag; w_err is low outside TRACK so both hold in HALT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mismatch <= 1'b0;
            r_sticky   <= 1'b0;
        end else begin
            r_mismatch <= w_err;
            r_sticky   <= r_sticky | w_err;
        end
    end

    // Previous terminal-count sample for edge detection, frozen in HALT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev_ter <= 1'b0;
        end else if (r_state != ST_HALT) begin
            r_prev_ter <= bus.tercnt;
        end
    end

    sat_counter #(.STAT_W(STAT_W)) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_err),
        .clr   (1'b0),
        .value (w_err_cnt)
    );

    sat_counter #(.STAT_W(STAT_W)) u_term_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_ter_rise),
        .clr   (1'b0),
        .value (w_term_cnt)
    );

    assign bus.synced     = (r_state != ST_UNSYNC);
    assign bus.mismatch   = r_mismatch;
    assign bus.err_sticky = r_sticky;
    assign bus.err_cnt    = w_err_cnt;
    assign bus.term_cnt   = w_term_cnt;
    assign bus.exp_count  = r_exp;

endmodule

// File: doc/bictr_checker.md
# bictr_checker

Synthesizable companion checker for the up/down binary counter with dynamic count-to flag. It sits on the consuming side of the counter's interface and observes its control inputs and its `count`/`tercnt` outputs. It runs a cycle-accurate shadow model, flags any divergence, and keeps saturating statistics for error and terminal-count events. It is used in simulation benches and can stay in silicon as a built-in self-check.

## Interface
- `WIDTH`, 8: counter width; must match the observed counter.
- `STAT_W`, 16: width of the saturating statistics counters.
- `STOP_ON_ERR`, 0: when 1, the checker freezes in HALT on the first mismatch.

Ports:
- `clk`  in  1  single clock, shared with the observed counter.
- `reset`  in  1  asynchronous, active-high checker reset. Independent of the counter's own reset.
- `dut_reset_n`  in  1  observed counter reset, active-low.
- `load`  in  1  observed load, active-low.
- `cen`  in  1  observed count enable, active-high.
- `up_dn`  in  1  observed direction: 1 = up, 0 = down.
- `data`  in  WIDTH  observed load value.
- `count_to`  in  WIDTH  observed terminal value.
- `count`  in  WIDTH  observed counter output.
- `tercnt`  in  1  observed terminal-count flag.
- `synced`  out  1  the shadow model is valid (state TRACK or HALT).
- `mismatch`  out  1  one-cycle pulse on each detected error.
- `err_sticky`  out  1  set on the first error; cleared only by `reset`.
- `err_cnt`  out  STAT_W  saturating count of errors.
- `term_cnt`  out  STAT_W  saturating count of `tercnt` rising edges while synced.
- `exp_count`  out  WIDTH  current shadow-model value.

## Operation
Counter behaviour being modelled:
- The counter is registered.
- `dut_reset_n` = 0 forces count to 0. It is asynchronous on the counter side; the checker samples it on `clk`.
- Otherwise, `load` = 0 loads `data`. Load has priority over `cen`.
- Otherwise, `cen` = 1 steps the count ±1 modulo 2^WIDTH, per `up_dn`. Wrap-around is legal and is not an error.
- Otherwise, the count holds.
- `tercnt` is combinational: `count == count_to`.

FSM states: UNSYNC, TRACK, HALT.
- UNSYNC: the entry state after `reset`. No comparisons are made.
  - If a sampled `dut_reset_n` = 0, seed the model with 0 and go to TRACK.
  - Else if a sampled `load` = 0, seed the model with `data` and go to TRACK.
  - Otherwise stay in UNSYNC.
- TRACK: on every edge:
  - Compare the sampled `count` against `exp_count`.
  - Compare the sampled `tercnt` against (sampled `count` == sampled `count_to`).
  - Either inequality is an error.
  - Update the model from the sampled controls, using the priority order above.
  - After an error, the model is reseeded from the observed `count` before the update, so a single fault is counted once.
  - If `STOP_ON_ERR` = 1 and an error occurs, go to HALT.
- HALT: all registers are frozen except `term_cnt`, which is also frozen. `synced` stays 1. Exit is only via `reset`.

Arithmetic:
- All model arithmetic is WIDTH bits with natural wrap.
- The statistics counters saturate at 2^STAT_W−1.

## Timing
- Reset values: state = UNSYNC; `synced` = 0, `mismatch` = 0, `err_sticky` = 0, `err_cnt` = 0, `term_cnt` = 0, `exp_count` = 0.
- Prediction: the model predicts the value the counter shows after edge N, using the controls sampled at edge N. The comparison happens at edge N+1.
- `mismatch` is registered. It asserts in the cycle after the edge at which the bad value was sampled, and `err_sticky` and `err_cnt` update on that same edge.
- `synced` rises one cycle after the seeding edge. The first comparison is made at the following edge.
- If `dut_reset_n` = 0 is sampled while in TRACK, the model is forced to 0. This is not an error.
- Simultaneous `load` = 0 and `cen` = 1: the load wins.
- `term_cnt` counts a rising edge when the previous sample of `tercnt` was 0 and the current sample is 1, while synced.
- Asserting `reset` mid-operation returns the checker to UNSYNC immediately, with all outputs at their reset values.

## Structure
- Shared package `bictr_pkg` holds:
  - the FSM state enum (UNSYNC/TRACK/HALT);
  - the next-count function `(cur, load_n, data, cen, up_dn) -> next`, so the same function is reused by any future counter-side blocks.
- Sub-module `sat_counter`, parameterised by STAT_W, with inputs `inc`, `clr` and output `value`. It is instantiated twice, for `err_cnt` and `term_cnt`.

## Test plan
- WIDTH=4. Hold `dut_reset_n` low for 1 cycle, then count up with `cen`=1 and `count_to`=4 from 0. Required: `synced` rises; no `mismatch`; `term_cnt` = 1 after `count` passes 4.
- Load `data`=1010 (`load`=0), then count up 8 cycles. Required: wrap 1111→0000 produces no error; `exp_count` = 0010.
- Counting down from 0000 with `up_dn`=0. Required: `exp_count` = 1111 with no error. Then apply `load`=0 together with `cen`=1, `data`=0011. Required: `exp_count` = 0011.
- Force the observed `count` to 0110 for one cycle when 0101 is expected. Required: a one-cycle `mismatch`, `err_sticky`=1, `err_cnt`=1, and no follow-on errors.
- Force `tercnt`=0 while `count`=`count_to`=0100. Required: `mismatch` pulse and `err_cnt` increments. With `STOP_ON_ERR`=1, the checker enters HALT and `err_cnt` stays frozen despite further faults.
- STAT_W=2: inject 5 errors. Required: `err_cnt` saturates at 3. Then assert `reset` mid-count. Required: all outputs are 0, state is UNSYNC, and there is no comparison until the next seed.
